// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   WAIT_W  : width of the video wait counter (holds MAX_WAIT up to 15)
//   DATA_W  : data-memory word width
//   grant_t : which requester owns the memory port in the current cycle
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int WAIT_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_VID  = 2'd2
  } grant_t;

endpackage

// File: rtl/dmem_arb_waitcnt.sv
// -----------------------------------------------------------------------------
// dmem_arb_waitcnt
// Saturating counter of cycles a video request has been kept waiting.
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset, clears the count
//   clr_i      : clear the count (video granted this cycle); wins over inc_i
//   inc_i      : video waited this cycle; counts up to MAX_WAIT, never wraps
//   cnt_o      : current count
//   at_limit_o : count has reached MAX_WAIT, video may preempt the CPU
// -----------------------------------------------------------------------------
module dmem_arb_waitcnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [WAIT_W-1:0] cnt_o,
  output logic              at_limit_o
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the core load/store path and
// the video scanout reader. The CPU wins by default; video is served in
// CPU-idle cycles, or preempts the CPU for one cycle once it has waited
// MAX_WAIT contested cycles. The CPU is stalled during a preemption.
//
// Optional build macro: DMEM_ARB_STATS_EN adds saturating statistics
// outputs stat_force (forced preemptions) and stat_stall (CPU stall cycles).
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   : core memory request
//   cpu_rdata               : load data, combinational from mem_rdata
//   cpu_stall               : core must hold PC and request this cycle
//   vid_req/vid_addr        : video read request, held until vid_ack
//   vid_rdata/vid_ack       : registered video read word and its 1-cycle strobe
//   mem_addr/we/wdata/rdata : data-memory port (combinational read)
//   stat_force/stat_stall   : statistics (only with DMEM_ARB_STATS_EN)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned VADDR_W  = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [DATA_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_stall,
  input  logic               vid_req,
  input  logic [VADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0]  vid_rdata,
  output logic               vid_ack,
  output logic [DATA_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]        stat_force,
  output logic [15:0]        stat_stall
`endif
);

  logic              pending_ack_q;
  logic              vid_ack_q;
  logic [DATA_W-1:0] vid_rdata_q;

  logic              at_limit;
  logic [WAIT_W-1:0] wait_cnt;
  logic              vid_live;
  logic              force_vid;
  logic              gnt_vid;
  logic              gnt_cpu;
  grant_t            grant;

  // pending_ack masks the ack cycle, where vid_req is still high for the
  // request just served; without it the same word would be read twice.
  assign vid_live  = vid_req & ~pending_ack_q;
  assign force_vid = vid_live & at_limit;
  assign gnt_vid   = vid_live & (~cpu_req | force_vid);
  assign gnt_cpu   = cpu_req & ~gnt_vid;

  always_comb begin
    grant = GNT_NONE;
    if (gnt_vid) begin
      grant = GNT_VID;
    end else if (gnt_cpu) begin
      grant = GNT_CPU;
    end
  end

  dmem_arb_waitcnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_waitcnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (gnt_vid),
    .inc_i      (vid_live & ~gnt_vid),
    .cnt_o      (wait_cnt),
    .at_limit_o (at_limit)
  );

  // Memory port mux. The write enable is qualified by the CPU grant so a
  // stalled store never reaches memory, and by reset_n so nothing is written
  // while reset is held.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;
    if (grant == GNT_VID) begin
      mem_addr = DATA_W'(vid_addr);
    end else begin
      mem_we = cpu_we & (grant == GNT_CPU) & reset_n;
    end
  end

  assign cpu_stall = cpu_req & gnt_vid & reset_n;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_rdata_q   <= '0;
      vid_ack_q     <= 1'b0;
      pending_ack_q <= 1'b0;
    end else begin
      vid_ack_q     <= gnt_vid;
      pending_ack_q <= gnt_vid;
      if (gnt_vid) begin
        vid_rdata_q <= mem_rdata;
      end
    end
  end

  assign vid_rdata = vid_rdata_q;
  assign vid_ack   = vid_ack_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_force_q;
  logic [15:0] stat_stall_q;

  // A preemption is a forced grant that actually displaced a CPU request;
  // forced grants in a CPU-idle cycle cost the core nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_force_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (force_vid && cpu_req && (stat_force_q != 16'hFFFF)) begin
        stat_force_q <= stat_force_q + 16'd1;
      end
      if (cpu_stall && (stat_stall_q != 16'hFFFF)) begin
        stat_stall_q <= stat_stall_q + 16'd1;
      end
    end
  end

  assign stat_force = stat_force_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural word-addressed data
// memory attached to the mem_* port. Inputs change 1 ns after the rising
// edge; combinational outputs are sampled 1 ns later, registered outputs
// just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int VADDR_W  = 9;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               cpu_req;
  logic               cpu_we;
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic [31:0]        cpu_rdata;
  logic               cpu_stall;
  logic               vid_req;
  logic [VADDR_W-1:0] vid_addr;
  logic [31:0]        vid_rdata;
  logic               vid_ack;
  logic [31:0]        mem_addr;
  logic               mem_we;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]        stat_force;
  logic [15:0]        stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .VADDR_W  (VADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_rdata (vid_rdata),
    .vid_ack   (vid_ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_force (stat_force),
    .stat_stall (stat_stall)
`endif
  );

  // Behavioural dmem: 128 words, combinational read, write on posedge.
  // Contents are (re)loaded while reset is held.
  logic [31:0] ram [0:127];

  assign mem_rdata = ram[mem_addr[8:2]];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 128; i++) ram[i] <= 32'h0;
      ram[7]  <= 32'hDEAD_BEEF;
      ram[8]  <= 32'h1111_1111;
      ram[12] <= 32'hCAFE_F00D;
    end else if (mem_we) begin
      ram[mem_addr[8:2]] <= mem_wdata;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [VADDR_W-1:0] vtab_addr [0:2];
  logic [31:0]        vtab_data [0:2];

  initial begin
    vtab_addr[0] = 9'h030; vtab_data[0] = 32'hCAFE_F00D;
    vtab_addr[1] = 9'h01C; vtab_data[1] = 32'hDEAD_BEEF;
    vtab_addr[2] = 9'h030; vtab_data[2] = 32'hCAFE_F00D;

    // ---- reset with a store presented ----
    reset_n   = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'hFFFF_FFFF;
    vid_req   = 1'b0;
    vid_addr  = '0;
    repeat (3) tick();
    check_value("reset mem_we", 32'(mem_we), 32'd0);
    check_value("reset cpu_stall", 32'(cpu_stall), 32'd0);
    check_value("reset vid_ack", 32'(vid_ack), 32'd0);
    check_value("reset vid_rdata", vid_rdata, 32'h0);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    reset_n = 1'b1;
    tick();

    // ---- idle video read ----
    vid_req  = 1'b1;
    vid_addr = 9'h01C;
    settle();
    check_value("idle mem_addr", mem_addr, 32'h1C);
    check_value("idle cpu_stall", 32'(cpu_stall), 32'd0);
    tick();
    check_value("idle vid_ack", 32'(vid_ack), 32'd1);
    check_value("idle vid_rdata", vid_rdata, 32'hDEAD_BEEF);
    settle();
    check_value("masked mem_addr", mem_addr, 32'h10);
    tick();
    check_value("masked vid_ack", 32'(vid_ack), 32'd0);
    vid_req = 1'b0;
    tick();

    // ---- three forced preemptions under continuous CPU traffic ----
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    vid_req = 1'b1;
    for (int p = 0; p < 3; p++) begin
      vid_addr = vtab_addr[p];
      for (int c = 0; c < MAX_WAIT; c++) begin
        cpu_we   = 1'b0;
        cpu_addr = 32'h100 + 32'(c * 4);
        settle();
        check_value($sformatf("p%0d c%0d cpu_stall", p, c), 32'(cpu_stall), 32'd0);
        check_value($sformatf("p%0d c%0d mem_addr", p, c), mem_addr, cpu_addr);
        tick();
        check_value($sformatf("p%0d c%0d vid_ack", p, c), 32'(vid_ack), 32'd0);
      end
      if (p == 0) begin
        cpu_we    = 1'b1;
        cpu_addr  = 32'h20;
        cpu_wdata = 32'h1234_5678;
      end
      settle();
      check_value($sformatf("p%0d forced cpu_stall", p), 32'(cpu_stall), 32'd1);
      check_value($sformatf("p%0d forced mem_addr", p), mem_addr, 32'(vtab_addr[p]));
      check_value($sformatf("p%0d forced mem_we", p), 32'(mem_we), 32'd0);
      tick();
      check_value($sformatf("p%0d vid_ack", p), 32'(vid_ack), 32'd1);
      check_value($sformatf("p%0d vid_rdata", p), vid_rdata, vtab_data[p]);
      if (p == 0) check_value("stalled store blocked", ram[8], 32'h1111_1111);
      settle();
      check_value($sformatf("p%0d after cpu_stall", p), 32'(cpu_stall), 32'd0);
      if (p == 0) check_value("held store mem_we", 32'(mem_we), 32'd1);
      tick();
      check_value($sformatf("p%0d after vid_ack", p), 32'(vid_ack), 32'd0);
      if (p == 0) check_value("held store committed", ram[8], 32'h1234_5678);
      cpu_we = 1'b0;
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    check_value("stat_force x3", 32'(stat_force), 32'd3);
    check_value("stat_stall x3", 32'(stat_stall), 32'd3);
`endif
    tick();

    // ---- CPU store then video read of the same word ----
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h40;
    cpu_wdata = 32'hA5A5_A5A5;
    settle();
    check_value("store mem_we", 32'(mem_we), 32'd1);
    tick();
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    vid_req  = 1'b1;
    vid_addr = 9'h040;
    settle();
    check_value("rd-after-wr mem_addr", mem_addr, 32'h40);
    tick();
    check_value("rd-after-wr vid_ack", 32'(vid_ack), 32'd1);
    check_value("rd-after-wr vid_rdata", vid_rdata, 32'hA5A5_A5A5);
    tick();
    vid_req = 1'b0;
    tick();

    // ---- reset in the middle of a waiting video request ----
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0;
    vid_req  = 1'b1;
    vid_addr = 9'h01C;
    repeat (3) tick();
    cpu_we    = 1'b1;
    cpu_addr  = 32'h44;
    cpu_wdata = 32'hBAD0_BAD0;
    reset_n   = 1'b0;
    settle();
    check_value("midrst mem_we", 32'(mem_we), 32'd0);
    check_value("midrst cpu_stall", 32'(cpu_stall), 32'd0);
    check_value("midrst vid_rdata", vid_rdata, 32'h0);
    tick();
    tick();
    check_value("midrst vid_ack", 32'(vid_ack), 32'd0);
    cpu_we  = 1'b0;
    reset_n = 1'b1;
    // The wait count restarted from zero, so the full bound applies again.
    for (int c = 0; c < MAX_WAIT; c++) begin
      settle();
      check_value($sformatf("postrst c%0d cpu_stall", c), 32'(cpu_stall), 32'd0);
      tick();
      check_value($sformatf("postrst c%0d vid_ack", c), 32'(vid_ack), 32'd0);
    end
    settle();
    check_value("postrst forced cpu_stall", 32'(cpu_stall), 32'd1);
    tick();
    check_value("postrst vid_ack", 32'(vid_ack), 32'd1);
    check_value("postrst vid_rdata", vid_rdata, 32'hDEAD_BEEF);
`ifdef DMEM_ARB_STATS_EN
    check_value("postrst stat_force", 32'(stat_force), 32'd1);
    check_value("postrst stat_stall", 32'(stat_stall), 32'd1);
`endif
    vid_req = 1'b0;
    cpu_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
